// File: rtl/multi_pwm_controller.sv
// rtl/multi_pwm_controller.sv - multi-channel PWM with debounced duty buttons and host duty load
// Shadow duties take button/host edits; active duties follow them only at period boundaries.
module multi_pwm_controller #(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 10,
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 5,
  parameter int DEB_DIV   = 2,
  parameter int CENTER    = 0,
  localparam int LCH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       inc_btn,
  input  logic [CHANNELS-1:0]       dec_btn,
  input  logic                      load_valid,
  input  logic [LCH_W-1:0]          load_ch,
  input  logic [CNT_W-1:0]          load_duty,
  output logic                      load_ready,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*CNT_W-1:0] duty_out,
  output logic [CHANNELS-1:0]       inc_pulse,
  output logic [CHANNELS-1:0]       dec_pulse,
  output logic                      period_tick
);

  localparam int PRE_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DEB_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_V    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] STEP_V   = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] INIT_V   = CNT_W'(DUTY_INIT);
  localparam logic [LCH_W:0]   CH_LIMIT = (LCH_W + 1)'(CHANNELS);

  logic [PRE_W-1:0]    pre_cnt;
  logic                deb_tick;
  logic [CNT_W-1:0]    cnt;
  logic                dir_down;
  logic [CHANNELS-1:0] inc_s1, inc_s2, dec_s1, dec_s2;
  logic [CHANNELS-1:0] inc_req, dec_req;
  logic [CHANNELS-1:0] inc_hit, dec_hit;
  logic [CNT_W-1:0]    shadow     [CHANNELS];
  logic [CNT_W-1:0]    active     [CHANNELS];
  logic [CNT_W-1:0]    shadow_nxt [CHANNELS];
  logic                load_hit;
  logic [CNT_W-1:0]    load_val;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] s;
    s = {1'b0, v} + {1'b0, STEP_V};
    return (s > {1'b0, PER_V}) ? PER_V : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v < STEP_V) ? '0 : v - STEP_V;
  endfunction

  assign deb_tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (deb_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

  // Center mode dwells one extra cycle at each extreme so up and down phases are PERIOD long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (CENTER == 0) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
    end else if (!dir_down) begin
      if (cnt == CNT_LAST) dir_down <= 1'b1;
      else                 cnt      <= cnt + CNT_ONE;
    end else begin
      if (cnt == '0) dir_down <= 1'b0;
      else           cnt      <= cnt - CNT_ONE;
    end
  end

  always_comb begin
    if (CENTER == 0) period_tick = (cnt == CNT_LAST);
    else             period_tick = dir_down && (cnt == '0);
  end

  assign load_ready = rst_n & ~period_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_s1 <= '0;
      inc_s2 <= '0;
      dec_s1 <= '0;
      dec_s2 <= '0;
    end else if (deb_tick) begin
      inc_s1 <= inc_btn;
      inc_s2 <= inc_s1;
      dec_s1 <= dec_btn;
      dec_s2 <= dec_s1;
    end
  end

  assign inc_req  = inc_s1 & ~inc_s2 & {CHANNELS{deb_tick}};
  assign dec_req  = dec_s1 & ~dec_s2 & {CHANNELS{deb_tick}};
  assign load_hit = load_valid && load_ready && ({1'b0, load_ch} < CH_LIMIT);
  assign load_val = (load_duty > PER_V) ? PER_V : load_duty;

  // Host load wins over buttons; opposing presses on one channel cancel.
  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      shadow_nxt[ch] = shadow[ch];
      if (load_hit && (load_ch == LCH_W'(ch))) begin
        shadow_nxt[ch] = load_val;
      end else if (inc_req[ch] && !dec_req[ch]) begin
        shadow_nxt[ch] = sat_inc(shadow[ch]);
        inc_hit[ch]    = (sat_inc(shadow[ch]) != shadow[ch]);
      end else if (dec_req[ch] && !inc_req[ch]) begin
        shadow_nxt[ch] = sat_dec(shadow[ch]);
        dec_hit[ch]    = (sat_dec(shadow[ch]) != shadow[ch]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        shadow[ch]                   <= INIT_V;
        active[ch]                   <= INIT_V;
        duty_out[ch*CNT_W +: CNT_W]  <= INIT_V;
      end
      inc_pulse <= '0;
      dec_pulse <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        shadow[ch]                  <= shadow_nxt[ch];
        duty_out[ch*CNT_W +: CNT_W] <= active[ch];
        if (period_tick) active[ch] <= shadow[ch];
      end
      inc_pulse <= inc_hit;
      dec_pulse <= dec_hit;
    end
  end

  always_comb begin
    pwm_out = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      pwm_out[ch] = (cnt < active[ch]);
    end
  end

endmodule
